// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game core: FSM states, symbol types,
// and conversions between 2-bit symbol indices and one-hot switch patterns.
package simon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXTEND,
      SHOW,
      WAIT_IN,
      CHECK,
      FAIL,
      WIN
   } state_t;

   typedef logic [1:0] sym_idx_t;
   typedef logic [3:0] sym_t;

   localparam int LFSR_W = 8;

   function automatic sym_t idx2sym(sym_idx_t idx);
      return sym_t'(4'b0001 << idx);
   endfunction

   function automatic logic is_onehot4(sym_t s);
      return $onehot(s);
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances only when enabled; exposes
// its two low bits as the next symbol index.
module simon_lfsr
   import simon_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     enable,
   output sym_idx_t idx
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic              feedback;

   // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
      lfsr_d   = lfsr_q;
      if (enable) begin
         lfsr_d = {lfsr_q[6:0], feedback};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign idx = lfsr_q[1:0];

endmodule

// File: rtl/sequence_checker.sv
// Simon game core: grows the sequence one LFSR symbol per round, replays it over
// a valid/ready handshake, and checks each committed press against it.
module sequence_checker
   import simon_pkg::*;
#(
   parameter int               MAX_LEN = 16,
   parameter logic [LFSR_W-1:0] SEED    = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       on_off,
   input  logic       start,
   input  logic [3:0] to_cmp,
   input  logic       input_done,
   input  logic       show_ready,
   output logic       show_valid,
   output logic [3:0] show_sym,
   output logic       accept_in,
   output logic       match,
   output logic       fail,
   output logic       win,
   output logic [5:0] round
);

   localparam int RW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(MAX_LEN);

   logic     game_rst_n;
   sym_idx_t lfsr_idx;
   logic     lfsr_en;

   state_t        state_q, state_d;
   logic [RW-1:0] round_q, round_d;
   logic [RW-1:0] step_q, step_d;
   sym_t          press_q, press_d;
   sym_idx_t      seq_q [MAX_LEN];
   sym_idx_t      seq_d [MAX_LEN];

   logic show_valid_q, show_valid_d;
   sym_t show_sym_q, show_sym_d;
   logic accept_in_q, accept_in_d;
   logic match_q, match_d;
   logic fail_q, fail_d;
   logic win_q, win_d;

   logic last_step;
   sym_t cur_sym;

   // Powering off is indistinguishable from reset, including reseeding the LFSR.
   assign game_rst_n = reset & on_off;

   simon_lfsr #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .reset  (game_rst_n),
      .enable (lfsr_en),
      .idx    (lfsr_idx)
   );

   assign last_step = (step_q == round_q - RW'(1));
   assign cur_sym   = idx2sym(seq_q[step_q[IW-1:0]]);

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      step_d  = step_q;
      press_d = press_q;
      seq_d   = seq_q;
      lfsr_en = 1'b0;
      match_d = 1'b0;
      fail_d  = fail_q;
      win_d   = win_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = EXTEND;
         end
         EXTEND: begin
            seq_d[round_q[IW-1:0]] = lfsr_idx;
            lfsr_en = 1'b1;
            round_d = round_q + RW'(1);
            step_d  = '0;
            state_d = SHOW;
         end
         SHOW: begin
            if (show_valid_q && show_ready) begin
               if (last_step) begin
                  step_d  = '0;
                  state_d = WAIT_IN;
               end else begin
                  step_d = step_q + RW'(1);
               end
            end
         end
         WAIT_IN: begin
            if (input_done) begin
               press_d = to_cmp;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (is_onehot4(press_q) && (press_q == cur_sym)) begin
               match_d = 1'b1;
               if (!last_step) begin
                  step_d  = step_q + RW'(1);
                  state_d = WAIT_IN;
               end else if (round_q == RW'(MAX_LEN)) begin
                  win_d   = 1'b1;
                  state_d = WIN;
               end else begin
                  state_d = EXTEND;
               end
            end else begin
               fail_d  = 1'b1;
               state_d = FAIL;
            end
         end
         FAIL, WIN: begin
            if (start) begin
               fail_d  = 1'b0;
               win_d   = 1'b0;
               round_d = '0;
               step_d  = '0;
               state_d = EXTEND;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state; reading seq_d lets the very
      // symbol written in EXTEND be presented on the first SHOW cycle.
      show_valid_d = (state_d == SHOW);
      accept_in_d  = (state_d == WAIT_IN);
      show_sym_d   = (state_d == SHOW) ? idx2sym(seq_d[step_d[IW-1:0]]) : '0;
   end

   always_ff @(posedge clk) begin
      if (!game_rst_n) begin
         state_q      <= IDLE;
         round_q      <= '0;
         step_q       <= '0;
         press_q      <= '0;
         show_valid_q <= 1'b0;
         show_sym_q   <= '0;
         accept_in_q  <= 1'b0;
         match_q      <= 1'b0;
         fail_q       <= 1'b0;
         win_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         step_q       <= step_d;
         press_q      <= press_d;
         show_valid_q <= show_valid_d;
         show_sym_q   <= show_sym_d;
         accept_in_q  <= accept_in_d;
         match_q      <= match_d;
         fail_q       <= fail_d;
         win_q        <= win_d;
      end
   end

   // NOTE: the sequence store has no reset; entries are only read below round_q, which is always written first.
   always_ff @(posedge clk) begin
      seq_q <= seq_d;
   end

   assign show_valid = show_valid_q;
   assign show_sym   = show_sym_q;
   assign accept_in  = accept_in_q;
   assign match      = match_q;
   assign fail       = fail_q;
   assign win        = win_q;
   assign round      = 6'(round_q);

endmodule

// File: tb/tb_sequence_checker.sv
// Directed game scenarios with random backpressure and random wrong presses,
// checked against a queue-based model of the Simon sequence and its LFSR.
module tb_sequence_checker;

   localparam int          MAX_LEN = 3;
   localparam logic [7:0] SEED    = 8'hA5;

   logic       clk;
   logic       reset;
   logic       on_off;
   logic       start;
   logic [3:0] to_cmp;
   logic       input_done;
   logic       show_ready;
   logic       show_valid;
   logic [3:0] show_sym;
   logic       accept_in;
   logic       match;
   logic       fail;
   logic       win;
   logic [5:0] round;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_lfsr;
   int         m_seq[$];

   sequence_checker #(.MAX_LEN(MAX_LEN), .SEED(SEED)) dut (
      .clk        (clk),
      .reset      (reset),
      .on_off     (on_off),
      .start      (start),
      .to_cmp     (to_cmp),
      .input_done (input_done),
      .show_ready (show_ready),
      .show_valid (show_valid),
      .show_sym   (show_sym),
      .accept_in  (accept_in),
      .match      (match),
      .fail       (fail),
      .win        (win),
      .round      (round)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] lfsr_next(logic [7:0] x);
      logic fb;
      fb = ^(x & 8'b1011_1000);
      return (x << 1) | 8'(fb);
   endfunction

   function automatic logic [3:0] sym_of(int idx);
      return 4'(1 << idx);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, 32'(show_valid), 0);
      check({tag, "_sym"}, 32'(show_sym), 0);
      check({tag, "_accept"}, 32'(accept_in), 0);
      check({tag, "_match"}, 32'(match), 0);
      check({tag, "_fail"}, 32'(fail), 0);
      check({tag, "_win"}, 32'(win), 0);
      check({tag, "_round"}, 32'(round), 0);
   endtask

   // Called while the DUT sits in EXTEND: model appends a symbol, DUT moves to SHOW.
   task automatic enter_show();
      check("extend_round", 32'(round), 32'(m_seq.size()));
      m_seq.push_back(int'(m_lfsr % 8'd4));
      m_lfsr = lfsr_next(m_lfsr);
      tick();
      check("match_pulse_end", 32'(match), 0);
   endtask

   task automatic start_game();
      m_seq.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_fail_clr", 32'(fail), 0);
      check("start_win_clr", 32'(win), 0);
      enter_show();
   endtask

   task automatic show_phase(input bit rand_bp);
      bit done;
      foreach (m_seq[i]) begin
         done = 1'b0;
         for (int c = 0; c < 16 && !done; c++) begin
            check("show_valid", 32'(show_valid), 1);
            check("show_sym", 32'(show_sym), 32'(sym_of(m_seq[i])));
            check("show_accept", 32'(accept_in), 0);
            show_ready = (!rand_bp || c >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            done = show_ready;
         end
      end
      check("show_end_valid", 32'(show_valid), 0);
      check("show_end_accept", 32'(accept_in), 1);
      check("show_end_round", 32'(round), 32'(m_seq.size()));
   endtask

   task automatic press(input logic [3:0] sym, input bit ok, input string tag);
      to_cmp     = sym;
      input_done = 1'b1;
      tick();
      input_done = 1'b0;
      to_cmp     = 4'($urandom_range(0, 15));
      check({tag, "_match_early"}, 32'(match), 0);
      check({tag, "_accept_chk"}, 32'(accept_in), 0);
      tick();
      check({tag, "_match"}, 32'(match), 32'(ok));
      check({tag, "_fail"}, 32'(fail), 32'(!ok));
   endtask

   task automatic answer_all(input string tag);
      for (int i = 0; i < m_seq.size(); i++) begin
         press(sym_of(m_seq[i]), 1'b1, tag);
         if (i < m_seq.size() - 1) check({tag, "_accept_next"}, 32'(accept_in), 1);
      end
   endtask

   initial begin
      int wrong_idx;

      reset      = 1'b0;
      on_off     = 1'b1;
      start      = 1'b0;
      to_cmp     = '0;
      input_done = 1'b0;
      show_ready = 1'b0;
      m_lfsr     = SEED;

      repeat (2) tick();
      check_quiet("reset");
      reset = 1'b1;
      tick();
      check_quiet("idle");

      // Backpressure on the first symbol, with a stray press during SHOW.
      start_game();
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 32'(show_valid), 1);
         check("bp_sym", 32'(show_sym), 32'(sym_of(m_seq[0])));
         check("bp_accept", 32'(accept_in), 0);
         input_done = (c == 2);
         to_cmp     = sym_of(m_seq[0]);
         tick();
      end
      input_done = 1'b0;
      check("show_press_ignored", 32'(match), 0);
      show_phase(1'b0);

      // Play correctly through MAX_LEN rounds to a win.
      answer_all("r1");
      enter_show();
      show_phase(1'b1);
      answer_all("r2");
      enter_show();
      show_phase(1'b1);
      answer_all("r3");
      check("win_set", 32'(win), 1);
      check("win_round", 32'(round), MAX_LEN);

      to_cmp     = sym_of(m_seq[0]);
      input_done = 1'b1;
      tick();
      input_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("win_hold", 32'(win), 1);
         check("win_no_match", 32'(match), 0);
         check("win_round_hold", 32'(round), MAX_LEN);
         check("win_accept", 32'(accept_in), 0);
         tick();
      end

      // New game (LFSR continues): non-one-hot press fails in round 1.
      start_game();
      show_phase(1'b0);
      press(4'b0011, 1'b0, "nonhot");
      check("nonhot_round", 32'(round), 1);
      tick();
      check("fail_hold", 32'(fail), 1);
      check("fail_no_match", 32'(match), 0);
      check("fail_accept", 32'(accept_in), 0);
      check("fail_round_hold", 32'(round), 1);

      // Restart from FAIL, then a wrong one-hot press in round 2.
      start_game();
      show_phase(1'b0);
      answer_all("g3r1");
      enter_show();
      show_phase(1'b1);
      wrong_idx = (m_seq[0] + 1 + int'($urandom_range(0, 2))) % 4;
      press(sym_of(wrong_idx), 1'b0, "wrong");
      check("wrong_round", 32'(round), 2);

      // Reset in the middle of the round-3 replay.
      start_game();
      show_phase(1'b1);
      answer_all("g4r1");
      enter_show();
      show_phase(1'b1);
      answer_all("g4r2");
      enter_show();
      show_ready = 1'b1;
      check("mid_sym0", 32'(show_sym), 32'(sym_of(m_seq[0])));
      tick();
      check("mid_valid", 32'(show_valid), 1);
      check("mid_sym1", 32'(show_sym), 32'(sym_of(m_seq[1])));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_quiet("mid_reset");
      m_lfsr = SEED;

      // After reseed the first symbol repeats; power-off in WAIT_IN also resets.
      start_game();
      show_phase(1'b0);
      on_off = 1'b0;
      tick();
      on_off = 1'b1;
      check_quiet("power_off");
      m_lfsr = SEED;
      start_game();
      show_phase(1'b1);
      answer_all("g6r1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
